// File: rtl/conv2x2_hir_pkg.sv
// Shared sizes, FSM encoding and tap geometry for the 2x2 convolution engine.
// The optional done pulse is enabled by defining CONV2X2_HIR_DONE_EN.
package conv2x2_hir_pkg;

  localparam int DATA_W  = 32;
  localparam int IMG_DIM = 8;
  localparam int K_DIM   = 2;
  localparam int NPIX    = IMG_DIM * IMG_DIM;
  localparam int NTAP    = K_DIM * K_DIM;
  localparam int IMG_AW  = $clog2(NPIX);
  localparam int K_AW    = $clog2(NTAP);

  localparam logic [K_AW-1:0]   LAST_TAP = K_AW'(NTAP - 1);
  localparam logic [IMG_AW-1:0] LAST_PIX = IMG_AW'(NPIX - 1);

  typedef enum logic [2:0] {IDLE, KLOAD, TAP, DRAIN, WRITE} state_e;

  // Tap visiting order is (0,0),(0,1),(1,0),(1,1).
  localparam int TAP_ROW_OFF [NTAP] = '{0, 0, 1, 1};
  localparam int TAP_COL_OFF [NTAP] = '{0, 1, 0, 1};

  function automatic logic tap_in_range(input logic [IMG_AW-1:0] pix, input logic [K_AW-1:0] tap);
    int r;
    int c;
    r = int'(pix) / IMG_DIM;
    c = int'(pix) % IMG_DIM;
    return ((r + TAP_ROW_OFF[tap]) < IMG_DIM) && ((c + TAP_COL_OFF[tap]) < IMG_DIM);
  endfunction

  function automatic logic [IMG_AW-1:0] tap_addr(input logic [IMG_AW-1:0] pix, input logic [K_AW-1:0] tap);
    return IMG_AW'(int'(pix) + TAP_ROW_OFF[tap] * IMG_DIM + TAP_COL_OFF[tap]);
  endfunction

endpackage

// File: rtl/conv2x2_hir_engine_mac.sv
// Multiply-accumulate for one output pixel; clear wins over accumulate.
module conv2x2_mac
  import conv2x2_hir_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] coef_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] prod;

  always_comb begin
    prod  = data_i * coef_i;
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv2x2_hir_engine.sv
// Sequential 2x2 convolution over an 8x8 image: kernel load, 4 tap slots, drain, write per pixel.
// Define CONV2X2_HIR_DONE_EN to add a one-cycle done pulse after the final write.
module conv2x2_hir_engine
  import conv2x2_hir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              t,
  output logic              img_p0_addr_en,
  output logic [IMG_AW-1:0] img_p0_addr_data,
  output logic              img_p0_rd_en,
  input  logic [DATA_W-1:0] img_p0_rd_data,
  output logic              kernel_p0_addr_en,
  output logic [K_AW-1:0]   kernel_p0_addr_data,
  output logic              kernel_p0_rd_en,
  input  logic [DATA_W-1:0] kernel_p0_rd_data,
  output logic              output_p0_addr_en,
  output logic [IMG_AW-1:0] output_p0_addr_data,
  output logic              output_p0_wr_en,
  output logic [DATA_W-1:0] output_p0_wr_data,
  output state_e            dbg_state
`ifdef CONV2X2_HIR_DONE_EN
  ,
  output logic              done
`endif
);

  state_e            state_q, state_d;
  logic [K_AW-1:0]   cnt_q, cnt_d;
  logic [IMG_AW-1:0] pix_q, pix_d;
  logic [DATA_W-1:0] kreg_q [NTAP];
  logic              kcap_q;
  logic [K_AW-1:0]   kcap_idx_q;
  logic              tap_vld_q;
  logic [K_AW-1:0]   tap_idx_q;
  logic              k_rd;
  logic              i_rd;
  logic              wr;
  logic [DATA_W-1:0] acc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    k_rd    = 1'b0;
    i_rd    = 1'b0;
    wr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (t) begin
          state_d = KLOAD;
          cnt_d   = '0;
        end
      end
      KLOAD: begin
        k_rd = 1'b1;
        if (cnt_q == LAST_TAP) begin
          state_d = TAP;
          cnt_d   = '0;
          pix_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TAP: begin
        // Out-of-image taps keep their slot but issue no read.
        i_rd = tap_in_range(pix_q, cnt_q);
        if (cnt_q == LAST_TAP) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = WRITE;
      end
      WRITE: begin
        wr = 1'b1;
        if (pix_q == LAST_PIX) begin
          state_d = IDLE;
        end else begin
          pix_d   = pix_q + 1'b1;
          state_d = TAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pix_q      <= '0;
      kcap_q     <= 1'b0;
      kcap_idx_q <= '0;
      tap_vld_q  <= 1'b0;
      tap_idx_q  <= '0;
      for (int i = 0; i < NTAP; i++) begin
        kreg_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
      kcap_q     <= k_rd;
      kcap_idx_q <= cnt_q;
      tap_vld_q  <= i_rd;
      tap_idx_q  <= cnt_q;
      if (kcap_q) begin
        kreg_q[kcap_idx_q] <= kernel_p0_rd_data;
      end
    end
  end

  conv2x2_mac u_mac (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  ((state_q == TAP) && (cnt_q == '0)),
    .en_i   (tap_vld_q),
    .data_i (img_p0_rd_data),
    .coef_i (kreg_q[tap_idx_q]),
    .acc_o  (acc)
  );

  assign kernel_p0_rd_en     = k_rd;
  assign kernel_p0_addr_en   = k_rd;
  assign kernel_p0_addr_data = k_rd ? cnt_q : '0;
  assign img_p0_rd_en        = i_rd;
  assign img_p0_addr_en      = i_rd;
  assign img_p0_addr_data    = i_rd ? tap_addr(pix_q, cnt_q) : '0;
  assign output_p0_wr_en     = wr;
  assign output_p0_addr_en   = wr;
  assign output_p0_addr_data = wr ? pix_q : '0;
  assign output_p0_wr_data   = wr ? acc : '0;
  assign dbg_state           = state_q;

`ifdef CONV2X2_HIR_DONE_EN
  logic done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == WRITE) && (pix_q == LAST_PIX);
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_conv2x2_hir_engine.sv
// Self-checking bench for conv2x2_hir_engine: memory models, scoreboard queue, strobe timing monitor.
module tb_conv2x2_hir_engine;
  import conv2x2_hir_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        t   = 1'b0;
  logic        img_p0_addr_en, img_p0_rd_en;
  logic [5:0]  img_p0_addr_data;
  logic [31:0] img_p0_rd_data = '0;
  logic        kernel_p0_addr_en, kernel_p0_rd_en;
  logic [1:0]  kernel_p0_addr_data;
  logic [31:0] kernel_p0_rd_data = '0;
  logic        output_p0_addr_en, output_p0_wr_en;
  logic [5:0]  output_p0_addr_data;
  logic [31:0] output_p0_wr_data;
  state_e      dbg_state;
`ifdef CONV2X2_HIR_DONE_EN
  logic        done;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  conv2x2_hir_engine dut (
    .clk                 (clk),
    .rst                 (rst),
    .t                   (t),
    .img_p0_addr_en      (img_p0_addr_en),
    .img_p0_addr_data    (img_p0_addr_data),
    .img_p0_rd_en        (img_p0_rd_en),
    .img_p0_rd_data      (img_p0_rd_data),
    .kernel_p0_addr_en   (kernel_p0_addr_en),
    .kernel_p0_addr_data (kernel_p0_addr_data),
    .kernel_p0_rd_en     (kernel_p0_rd_en),
    .kernel_p0_rd_data   (kernel_p0_rd_data),
    .output_p0_addr_en   (output_p0_addr_en),
    .output_p0_addr_data (output_p0_addr_data),
    .output_p0_wr_en     (output_p0_wr_en),
    .output_p0_wr_data   (output_p0_wr_data),
    .dbg_state           (dbg_state)
`ifdef CONV2X2_HIR_DONE_EN
    ,
    .done                (done)
`endif
  );

  // ---------------- memory models (1-cycle read latency) ----------------
  logic [31:0] img_mem [64];
  logic [31:0] k_mem [4];

  always @(posedge clk) begin
    if (img_p0_rd_en) img_p0_rd_data <= img_mem[img_p0_addr_data];
    if (kernel_p0_rd_en) kernel_p0_rd_data <= k_mem[kernel_p0_addr_data];
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] out_mem [64];
  int          abs_cyc = 0;
  int          t0 = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          wr_cnt, img_rd_cnt, k_rd_cnt, done_cnt;
  int          first_img_cyc, first_img_addr, first_wr_cyc, last_wr_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_px(input int r, input int c);
    logic [31:0] sum;
    sum = '0;
    for (int kr = 0; kr < 2; kr++)
      for (int kc = 0; kc < 2; kc++)
        if (r + kr < 8 && c + kc < 8)
          sum = sum + img_mem[(r + kr) * 8 + c + kc] * k_mem[kr * 2 + kc];
    return sum;
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin : monitor
    logic bad;
    #1;
    abs_cyc++;
    cyc = abs_cyc - t0;
    if (mon_en) begin
      bad = (img_p0_addr_en != img_p0_rd_en) || (!img_p0_rd_en && img_p0_addr_data != 0) ||
            (kernel_p0_addr_en != kernel_p0_rd_en) || (!kernel_p0_rd_en && kernel_p0_addr_data != 0) ||
            (output_p0_addr_en != output_p0_wr_en) || (!output_p0_wr_en && output_p0_addr_data != 0) ||
            (!output_p0_wr_en && output_p0_wr_data != 0);
      check_eq("strobe_rules", {31'd0, bad}, 32'd0);
      if (kernel_p0_rd_en) begin
        check_eq("k_rd_cyc", {31'd0, (cyc >= 1 && cyc <= 4)}, 32'd1);
        check_eq("k_rd_addr", {30'd0, kernel_p0_addr_data}, cyc - 1);
        k_rd_cnt++;
      end
      if (img_p0_rd_en) begin
        if (img_rd_cnt == 0) begin
          first_img_cyc  = cyc;
          first_img_addr = int'(img_p0_addr_data);
        end
        img_rd_cnt++;
      end
      if (output_p0_wr_en) begin
        if (wr_cnt == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        check_eq("wr_addr", {26'd0, output_p0_addr_data}, wr_cnt);
        out_mem[output_p0_addr_data] = output_p0_wr_data;
        if (exp_q.size() == 0) check_eq("wr_unexpected", exp_q.size(), 1);
        else check_eq("wr_data", output_p0_wr_data, exp_q.pop_front());
        wr_cnt++;
      end
`ifdef CONV2X2_HIR_DONE_EN
      if (done) begin
        done_cnt++;
        check_eq("done_cyc", cyc, 389);
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input int n);
    for (int p = 0; p < n; p++) exp_q.push_back(model_px(p / 8, p % 8));
  endtask

  task automatic start_run();
    wr_cnt = 0; img_rd_cnt = 0; k_rd_cnt = 0; done_cnt = 0;
    first_img_cyc = -1; first_img_addr = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    @(negedge clk);
    t  = 1'b1;
    t0 = abs_cyc;
    @(negedge clk);
    t = 1'b0;
  endtask

  task automatic wait_cyc(input int target, input int budget);
    int i = 0;
    do begin
      @(posedge clk);
      #2;
      i++;
    end while (cyc < target && i < budget);
    check_eq("wait_cyc", {31'd0, cyc >= target}, 32'd1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int i = 0;
    while (wr_cnt < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    check_eq("wait_writes", wr_cnt, n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_en"}, {26'd0, img_p0_addr_en, img_p0_rd_en, kernel_p0_addr_en,
             kernel_p0_rd_en, output_p0_addr_en, output_p0_wr_en}, 32'd0);
    check_eq({tag, "_addr"}, {18'd0, img_p0_addr_data, kernel_p0_addr_data, output_p0_addr_data}, 32'd0);
    check_eq({tag, "_data"}, output_p0_wr_data, 32'd0);
    check_eq({tag, "_state"}, {29'd0, dbg_state}, {29'd0, IDLE});
`ifdef CONV2X2_HIR_DONE_EN
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
`endif
  endtask

  task automatic run_full(input bit mid_t);
    exp_q.delete();
    push_expected(64);
    start_run();
    if (mid_t) begin
      wait_cyc(100, 200);
      @(negedge clk);
      t = 1'b1;
      @(negedge clk);
      t = 1'b0;
    end
    wait_writes(64, 600);
    repeat (6) @(posedge clk);
    #2;
    check_eq("wr_count", wr_cnt, 64);
    check_eq("img_reads", img_rd_cnt, 225);
    check_eq("k_reads", k_rd_cnt, 4);
    check_eq("first_img_cyc", first_img_cyc, 5);
    check_eq("first_img_addr", first_img_addr, 0);
    check_eq("first_wr_cyc", first_wr_cyc, 10);
    check_eq("last_wr_cyc", last_wr_cyc, 388);
    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("end_idle", {29'd0, dbg_state}, {29'd0, IDLE});
`ifdef CONV2X2_HIR_DONE_EN
    check_eq("done_count", done_cnt, 1);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    t   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // Ramp image, all-ones kernel
    for (int i = 0; i < 64; i++) img_mem[i] = 32'(i + 1);
    for (int i = 0; i < 4; i++) k_mem[i] = 32'd1;
    run_full(1'b0);
    check_eq("ones_00", out_mem[0], 32'd22);
    check_eq("ones_66", out_mem[54], 32'd238);
    check_eq("ones_07", out_mem[7], 32'd24);
    check_eq("ones_70", out_mem[56], 32'd115);
    check_eq("ones_77", out_mem[63], 32'd64);

    // Identity-like kernel: only the (0,0) tap counts
    k_mem[0] = 32'd1; k_mem[1] = 32'd0; k_mem[2] = 32'd0; k_mem[3] = 32'd0;
    run_full(1'b0);
    check_eq("id_p0", out_mem[0], 32'd1);
    check_eq("id_p63", out_mem[63], 32'd64);

    // Overflow wraps mod 2^32
    for (int i = 0; i < 64; i++) img_mem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) k_mem[i] = 32'd2;
    run_full(1'b0);
    check_eq("ovf_00", out_mem[0], 32'hFFFF_FFF8);
    check_eq("ovf_77", out_mem[63], 32'hFFFF_FFFE);

    // Random data with a stray start pulse mid-run
    for (int i = 0; i < 64; i++) img_mem[i] = $urandom;
    for (int i = 0; i < 4; i++) k_mem[i] = $urandom_range(0, 1000);
    run_full(1'b1);

    // Reset abort at cycle 50: pixels 0..6 are written before it
    for (int i = 0; i < 64; i++) img_mem[i] = $urandom_range(0, 65535);
    for (int i = 0; i < 4; i++) k_mem[i] = $urandom_range(1, 9);
    exp_q.delete();
    push_expected(7);
    start_run();
    wait_cyc(50, 100);
    rst = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (40) @(posedge clk);
    #2;
    check_eq("abort_writes", wr_cnt, 7);
    check_eq("abort_queue", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Restart after abort reloads the kernel from address 0
    run_full(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv2x2_hir_engine.md
Name: conv2x2_hir_engine

Overview:
- Sequential 2x2-kernel convolution engine over an 8x8 image of 32-bit words, started by a one-cycle pulse on t.
- Reads the kernel memory and image memory through single-read ports and writes the 8x8 result through one write port.
- Sits between three external synchronous memories: image, kernel and output.
- Memories have 1-cycle read latency: data is valid in the cycle after rd_en.

Parameters:
- DATA_W, 32, word width of image, kernel, product and accumulator.
- IMG_DIM, 8, image/output side length; image address width is clog2(IMG_DIM*IMG_DIM)=6.
- K_DIM, 2, kernel side length; kernel address width is clog2(K_DIM*K_DIM)=2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- t  in  1  start pulse; sampled only in IDLE.
- img_p0_addr_en  out  1  equals img_p0_rd_en.
- img_p0_addr_data  out  6  image address, row-major (r*8+c).
- img_p0_rd_en  out  1  image read strobe.
- img_p0_rd_data  in  32  image data, valid the cycle after rd_en.
- kernel_p0_addr_en  out  1  equals kernel_p0_rd_en.
- kernel_p0_addr_data  out  2  kernel address (kr*2+kc).
- kernel_p0_rd_en  out  1  kernel read strobe.
- kernel_p0_rd_data  in  32  kernel data, valid the cycle after rd_en.
- output_p0_addr_en  out  1  equals output_p0_wr_en.
- output_p0_addr_data  out  6  output address (r*8+c).
- output_p0_wr_en  out  1  write strobe.
- output_p0_wr_data  out  32  result word.

Behaviour:
- Function: out[r][c] = sum over kr,kc in {0,1} of img[r+kr][c+kc]*k[kr][kc].
  - Taps with r+kr>7 or c+kc>7 contribute 0 and issue no read.
  - Multiply and add are unsigned, truncated mod 2^32.
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs go to 0: every enable, address and wr_data.
  - Accumulator and kernel registers clear.
- FSM states: IDLE, KLOAD, TAP, DRAIN, WRITE.
- Cycle numbering: cycle 0 is the cycle where t=1 is sampled in IDLE.
- KLOAD, cycles 1-4:
  - kernel_p0_rd_en=1 with addr 0,1,2,3.
  - Each word is captured into kreg[a] at the end of the following cycle.
- Pixel p (raster order, p=r*8+c):
  - TAP slots 0..3 at cycles 5+6p..8+6p, tap order (0,0),(0,1),(1,0),(1,1).
  - Each in-range slot asserts img_p0_rd_en with the tap's address.
  - Returned data is multiplied by kreg and added to acc in the next cycle.
  - The accumulator clears at the start of each pixel.
  - DRAIN at cycle 9+6p absorbs the slot-3 data.
  - WRITE at cycle 10+6p: output_p0_wr_en=1, addr=p, wr_data=acc (registered).
- After pixel 63 is written (cycle 388), return to IDLE.
- Enables are high only in their strobe cycles. Addresses return to 0 when their strobe is low.
- t asserted while not in IDLE is ignored; no restart.
- Reset mid-operation aborts immediately. No further writes are issued until the next t.

Optional Feature:
- Macro CONV2X2_HIR_DONE_EN.
- Defined: adds output port done (1 bit), pulsed high for exactly one cycle in the cycle after the final WRITE (cycle 389), 0 in reset.
- Undefined: no done port. Completion is inferred only from the final write.

Decomposition:
- Package conv2x2_hir_pkg holds:
  - DATA_W, IMG_DIM and K_DIM defaults;
  - derived address widths;
  - FSM state enum (IDLE, KLOAD, TAP, DRAIN, WRITE);
  - tap offset constants.
- One natural sub-module: conv2x2_mac. It takes a product of rd_data and the kernel word, accumulates it, and clears on pixel start.

Test Plan:
- Bench setup: clock generator plus one-cycle t pulse generator after reset release; memories with 1-cycle read latency.
- Stimulus: img[i]=i+1, kernel all 1, t pulse.
  - out[0][0]=22; generally out[r][c]=4*(8r+c)+22 for r,c<7 (out[6][6]=238).
  - Right edge out[0][7]=24; bottom edge out[7][0]=115; corner out[7][7]=64.
- Kernel {1,0,0,0}, same image -> out[p]=p+1 for all 64 pixels.
- Check strobe timing and counts:
  - kernel rd_en on cycles 1-4 only;
  - first image rd_en cycle 5 addr 0;
  - first wr_en cycle 10 addr 0; last wr_en cycle 388 addr 63;
  - exactly 64 writes, 225 image reads.
- Overflow: img all 0xFFFFFFFF, kernel all 2 -> out[0][0]=0xFFFFFFF8.
- Drive rst low at cycle 50 -> all outputs 0 immediately, no writes afterwards.
  - A new t after release restarts from kernel addr 0.
- Second t pulse mid-run ignored (still exactly 64 writes). With CONV2X2_HIR_DONE_EN, done high only at cycle 389.
